rr_decode_arbiter: RTL and testbench

- Round-robin arbiter sharing one resource among WIDTH requesters.
- Produces a one-hot grant vector plus a binary grant index.
- Holds each grant until the owner releases it or a hold timeout fires.
- Sits in front of shared buses and memories; the one-hot grant drives per-requester selects directly.

---
 rtl/rr_decode_arbiter_pkg.sv | 12 +
 rtl/rr_decode_arbiter_if.sv | 26 ++
 rtl/rr_decode_arbiter_chk.sv | 13 +
 rtl/rr_decode_arbiter_decoder.sv | 22 ++
 rtl/rr_decode_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_decode_arbiter.sv | 192 +++++++++++++++++++
 6 files changed

// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types and default constants for the round-robin decode arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_SIZE     = 3;
    localparam int ARB_MAX_HOLD = 16;

endpackage : arb_pkg

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_decode_arbiter_if
    import arb_pkg::*;
#(
    parameter int SIZE = ARB_SIZE
);
    logic                    en;
    logic [(1 << SIZE)-1:0]  req;
    logic                    done;
    logic [(1 << SIZE)-1:0]  gnt;
    logic [SIZE-1:0]         gnt_idx;
    logic                    gnt_valid;
    logic                    timeout;

    // Requester side: drives requests, observes grants.
    modport master (
        output en, req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    // Arbiter side.
    modport slave (
        input  en, req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface : rr_decode_arbiter_if

// File: rtl/rr_decode_arbiter_chk.sv
// Property checker: the grant vector is never more than one-hot.
module rr_decode_arbiter_chk #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    input logic [WIDTH-1:0] gnt
);

    gnt_onehot0_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
        else $error("grant vector not one-hot-or-zero: %b", gnt);

endmodule : rr_decode_arbiter_chk

// File: rtl/rr_decode_arbiter_decoder.sv
// Combinational binary-to-one-hot decoder with enable; all-zero when disabled.
module rr_decode_arbiter_decoder
    import arb_pkg::*;
#(
    parameter int SIZE = ARB_SIZE
) (
    input  logic                   en_i,
    input  logic [SIZE-1:0]        in_i,
    output logic [(1 << SIZE)-1:0] out_o
);

    // One-hot decode of the index, gated by the enable.
    always_comb begin
        out_o = '0;
        if (en_i) begin
            out_o[in_i] = 1'b1;
        end else begin
            out_o = '0;
        end
    end

endmodule : rr_decode_arbiter_decoder

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter: grants one requester at a time, holds the grant until
// release (done, dropped request, or hold timeout), then rotates priority.
module rr_decode_arbiter
    import arb_pkg::*;
#(
    parameter int SIZE     = ARB_SIZE,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input logic              clk,
    input logic              rst_n,
    rr_decode_arbiter_if.slave bus
);

    localparam int WIDTH = 1 << SIZE;
    // A zero-width counter is illegal, so the disabled-timeout case keeps one bit.
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_t       state_q, state_d;
    logic [SIZE-1:0]  ptr_q, ptr_d;
    logic [SIZE-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic             valid_d;
    logic             hit_limit;
    logic             owner_req;

    // First set request bit scanning from ptr upward, wrapping modulo WIDTH.
    function automatic logic [SIZE-1:0] rr_pick(input logic [WIDTH-1:0] r,
                                                 input logic [SIZE-1:0]  p);
        logic [SIZE-1:0] k;
        logic            found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            k = p + SIZE'(i);
            if (!found && r[k]) begin
                rr_pick = k;
                found   = 1'b1;
            end
        end
    endfunction

    // Next-state logic: arbitration in IDLE, release detection in BUSY.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        hit_limit = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));
        owner_req = bus.req[idx_q];
        case (state_q)
            IDLE: begin
                if (bus.en && (|bus.req)) begin
                    state_d = BUSY;
                    idx_d   = rr_pick(bus.req, ptr_q);
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (bus.done || !owner_req || hit_limit) begin
                    state_d   = IDLE;
                    ptr_d     = idx_q + SIZE'(1);
                    cnt_d     = '0;
                    // done or a dropped request takes precedence over the timeout.
                    timeout_d = hit_limit && !bus.done && owner_req;
                end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign valid_d = (state_d == BUSY);

    // Decode the next owner so the registered one-hot grant lines up with gnt_valid.
    rr_decode_arbiter_decoder #(.SIZE(SIZE)) u_dec (
        .en_i  (valid_d),
        .in_i  (idx_d),
        .out_o (gnt_d)
    );

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            gnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            gnt_q     <= gnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = (state_q == BUSY);
    assign bus.timeout   = timeout_q;

    rr_decode_arbiter_chk #(.WIDTH(WIDTH)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .gnt   (gnt_q)
    );

endmodule : rr_decode_arbiter

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter (SIZE=2, MAX_HOLD=4).
module tb_rr_decode_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    rr_decode_arbiter_if #(.SIZE(2)) bus ();

    rr_decode_arbiter #(.SIZE(2), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        step();
        step();
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got %b want %b", bus.gnt, 4'b0000); end
        n_cmp++; if (bus.gnt_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", bus.gnt_idx); end
        n_cmp++; if (bus.gnt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.gnt_valid); end
        n_cmp++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", bus.timeout); end
        rst_n = 1'b1;
        step();
    endtask

    // Single request, release by dropping req; then ptr=3 proven by req=1001 -> 3.
    task automatic test_single();
        bus.en  = 1'b1;
        bus.req = 4'b0100;
        step();
        n_cmp++; if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt got %b want %b", bus.gnt, 4'b0100); end
        n_cmp++; if (bus.gnt_idx !== 2'd2) begin n_err++; $display("FAIL single_idx got %0d want 2", bus.gnt_idx); end
        n_cmp++; if (bus.gnt_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", bus.gnt_valid); end
        bus.req = 4'b0000;
        step();
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL single_rel_gnt got %b want %b", bus.gnt, 4'b0000); end
        n_cmp++; if (bus.gnt_valid !== 1'b0) begin n_err++; $display("FAIL single_rel_valid got %b want 0", bus.gnt_valid); end
        n_cmp++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL single_rel_timeout got %b want 0", bus.timeout); end
        bus.req = 4'b1001;
        step();
        n_cmp++; if (bus.gnt !== 4'b1000) begin n_err++; $display("FAIL single_ptr3_gnt got %b want %b", bus.gnt, 4'b1000); end
        bus.done = 1'b1;
        bus.req  = 4'b0000;
        step();
        bus.done = 1'b0;
        // ptr is now 0
    endtask

    // All requesting, done each grant: order 0,1,2,3,0 with an idle bubble between.
    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        logic [1:0] order [5];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_gnt = 4'b0001 << order[i];
            n_cmp++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL rr_gnt[%0d] got %b want %b", i, bus.gnt, exp_gnt); end
            n_cmp++; if (bus.gnt_idx !== order[i]) begin n_err++; $display("FAIL rr_idx[%0d] got %0d want %0d", i, bus.gnt_idx, order[i]); end
            bus.done = 1'b1;
            if (i == 4) bus.req = 4'b0000;
            step();
            bus.done = 1'b0;
            n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL rr_bubble[%0d] got %b want %b", i, bus.gnt, 4'b0000); end
        end
        // ptr is now 1
    endtask

    // Wrap: move ptr to 3, then req=0011 must grant 0 before 1.
    task automatic test_wrap();
        bus.req = 4'b0100;
        step();
        n_cmp++; if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL wrap_setup got %b want %b", bus.gnt, 4'b0100); end
        bus.req = 4'b0000;
        step();
        bus.req = 4'b0011;
        step();
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL wrap_first got %b want %b", bus.gnt, 4'b0001); end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        n_cmp++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL wrap_timeout got %b want 0", bus.timeout); end
        step();
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL wrap_second got %b want %b", bus.gnt, 4'b0010); end
        bus.req = 4'b0000;
        step();
        // ptr is now 2
    endtask

    // Timeout: grant held exactly 4 cycles, one-cycle timeout pulse, re-grant after bubble.
    task automatic test_timeout();
        bus.req = 4'b0010;
        step();
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL to_hold[%0d] got %b want %b", c, bus.gnt, 4'b0010); end
            n_cmp++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL to_early[%0d] got %b want 0", c, bus.timeout); end
            step();
        end
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL to_rel_gnt got %b want %b", bus.gnt, 4'b0000); end
        n_cmp++; if (bus.timeout !== 1'b1) begin n_err++; $display("FAIL to_pulse got %b want 1", bus.timeout); end
        step();
        n_cmp++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL to_pulse_len got %b want 0", bus.timeout); end
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL to_regrant got %b want %b", bus.gnt, 4'b0010); end
        bus.req = 4'b0000;
        step();
        n_cmp++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL to_drop_timeout got %b want 0", bus.timeout); end
        // ptr is now 2
    endtask

    // done coincident with the timeout cycle suppresses the pulse; en gating of new grants.
    task automatic test_simultaneous();
        bus.req = 4'b0001;
        step();
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL sim_gnt got %b want %b", bus.gnt, 4'b0001); end
        step();
        step();
        step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL sim_rel got %b want %b", bus.gnt, 4'b0000); end
        n_cmp++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL sim_timeout got %b want 0", bus.timeout); end
        step();
        bus.en  = 1'b0;
        bus.req = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (bus.gnt_valid !== 1'b0) begin n_err++; $display("FAIL en_block[%0d] got %b want 0", c, bus.gnt_valid); end
        end
        bus.en = 1'b1;
        step();
        n_cmp++; if (bus.gnt !== 4'b1000) begin n_err++; $display("FAIL en_gnt got %b want %b", bus.gnt, 4'b1000); end
        n_cmp++; if (bus.gnt_idx !== 2'd3) begin n_err++; $display("FAIL en_idx got %0d want 3", bus.gnt_idx); end
        bus.req = 4'b0000;
        step();
        // ptr is now 0
    endtask

    // Async reset mid-grant drops the grant at once and returns ptr to 0.
    task automatic test_async_reset();
        bus.req = 4'b0110;
        step();
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL ar_setup got %b want %b", bus.gnt, 4'b0010); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL ar_gnt got %b want %b", bus.gnt, 4'b0000); end
        n_cmp++; if (bus.gnt_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got %b want 0", bus.gnt_valid); end
        n_cmp++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL ar_timeout got %b want 0", bus.timeout); end
        step();
        bus.req = 4'b1111;
        rst_n   = 1'b1;
        step();
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL ar_regrant got %b want %b", bus.gnt, 4'b0001); end
        n_cmp++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL ar_no_pulse got %b want 0", bus.timeout); end
        bus.req = 4'b0000;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_simultaneous();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rr_decode_arbiter
